// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the memory-stage LSU (master) and the data memory (slave).
// Request fields are qualified by mem_req; mem_rdata is qualified by mem_ready.
interface mem_stage_lsu_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDRESS_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      mem_ready;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit.
// Turns the EX/MEM address, store data and funct3 into a word-aligned request with byte
// enables, holds the pipeline stalled while the memory answers, and returns the
// sign/zero-extended load result. Misaligned, illegal-width and timed-out accesses raise
// a one-cycle fault pulse and clear the load result.
module mem_stage_lsu #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MAX_WAIT      = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ADDRESS_WIDTH-1:0] ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]    WriteDataM_i,
  input  logic                     MemWriteM_i,
  input  logic [1:0]               ResultSrcM_i,
  input  logic [2:0]               funct3M_i,
  mem_stage_lsu_if.master          mem_bus,
  output logic [DATA_WIDTH-1:0]    ReadDataM_o,
  output logic                     StallM_o,
  output logic                     FaultM_o
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Byte enables for an access of the given size (funct3[1:0]) at byte offset a.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane, so the byte enables alone pick the target.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      2'b10:   d = wd;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Select the addressed lane of the read word and extend it to register width.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = w;
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_e                   state_q;
  logic                     req_q;
  logic                     we_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [3:0]               be_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [2:0]               f3_q;
  logic [1:0]               off_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     fault_q;

  logic access_s;
  logic f3_legal_s;
  logic align_ok_s;
  logic legal_s;
  logic timeout_s;
  logic [3:0] be_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  assign access_s = MemWriteM_i | (ResultSrcM_i == 2'b01);
  assign legal_s  = f3_legal_s & align_ok_s;
  assign be_s     = lane_be(funct3M_i[1:0], ALUResultM_i[1:0]);
  assign wdata_s  = lane_wdata(funct3M_i[1:0], WriteDataM_i);

  // Decode funct3 legality and natural alignment of the incoming access.
  always_comb begin
    f3_legal_s = 1'b0;
    align_ok_s = 1'b0;
    case (funct3M_i)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd5: f3_legal_s = 1'b1;
      default:                      f3_legal_s = 1'b0;
    endcase
    case (funct3M_i[1:0])
      2'b00:   align_ok_s = 1'b1;
      2'b01:   align_ok_s = (ALUResultM_i[0] == 1'b0);
      2'b10:   align_ok_s = (ALUResultM_i[1:0] == 2'b00);
      default: align_ok_s = 1'b0;
    endcase
  end

  // Wait counter next value; the timeout fires on the cycle the count would reach MAX_WAIT.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    timeout_s = 1'b0;
    if (cnt_d == CNT_LAST) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Access FSM: latches the request, waits for the memory, returns the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      f3_q    <= 3'd0;
      off_q   <= 2'b00;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          fault_q <= 1'b0;
          if (access_s && legal_s) begin
            state_q <= ST_REQ;
            req_q   <= 1'b1;
            we_q    <= MemWriteM_i;
            addr_q  <= {ALUResultM_i[ADDRESS_WIDTH-1:2], 2'b00};
            be_q    <= be_s;
            wdata_q <= MemWriteM_i ? wdata_s : '0;
            f3_q    <= funct3M_i;
            off_q   <= ALUResultM_i[1:0];
            cnt_q   <= '0;
          end else if (access_s) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_REQ: begin
          if (mem_bus.mem_ready || timeout_s) begin
            // Completion beats timeout when ready arrives on the last permitted cycle.
            if (mem_bus.mem_ready) begin
              if (!we_q) begin
                rdata_q <= load_extend(f3_q, off_q, mem_bus.mem_rdata);
              end else begin
                rdata_q <= rdata_q;
              end
            end else begin
              fault_q <= 1'b1;
              rdata_q <= '0;
            end
            state_q <= ST_DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          // The pipeline advances on this edge, so the same instruction is never re-issued.
          fault_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= '0;
          be_q    <= 4'b0000;
          wdata_q <= '0;
          cnt_q   <= '0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  // The issue cycle must stall before the request register is set; reset forces it low.
  assign StallM_o = rst_ni & (req_q | ((state_q == ST_IDLE) & access_s & legal_s));

  assign mem_bus.mem_req   = req_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = addr_q;
  assign mem_bus.mem_be    = be_q;
  assign mem_bus.mem_wdata = wdata_q;
  assign ReadDataM_o       = rdata_q;
  assign FaultM_o          = fault_q;

  mem_stage_lsu_chk #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_chk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .mem_req   (mem_bus.mem_req),
    .mem_we    (mem_bus.mem_we),
    .mem_addr  (mem_bus.mem_addr),
    .mem_be    (mem_bus.mem_be),
    .mem_wdata (mem_bus.mem_wdata),
    .mem_ready (mem_bus.mem_ready),
    .FaultM_o  (FaultM_o)
  );

endmodule

// Bus protocol properties of the LSU master side.
module mem_stage_lsu_chk #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  input logic                     mem_req,
  input logic                     mem_we,
  input logic [ADDRESS_WIDTH-1:0] mem_addr,
  input logic [DATA_WIDTH/8-1:0]  mem_be,
  input logic [DATA_WIDTH-1:0]    mem_wdata,
  input logic                     mem_ready,
  input logic                     FaultM_o
);
  a_idle_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !mem_req |-> (!mem_we && (mem_addr == '0) && (mem_be == '0) && (mem_wdata == '0)));

  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req && !mem_ready) |=> (mem_req || FaultM_o));
endmodule
